// File: rtl/can_pkg.sv
// Shared CAN definitions: receive FSM states, frame field lengths, CRC-15 helpers.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA,
    ST_CRC, ST_CRC_DEL, ST_ACK, ST_ACK_DEL, ST_EOF, ST_ERROR, ST_IGNORE
  } can_rx_state_e;

  localparam logic [14:0] CAN_CRC_POLY      = 15'h4599;
  localparam int unsigned CAN_ID_LEN        = 11;
  localparam int unsigned CAN_DLC_LEN       = 4;
  localparam int unsigned CAN_CRC_LEN       = 15;
  localparam int unsigned CAN_EOF_LEN       = 7;
  localparam int unsigned CAN_IDLE_RECOVERY = 11;
  localparam int unsigned CAN_MIN_BIT_TIME  = 4;

  function automatic logic [14:0] can_crc15_step(input logic [14:0] crc, input logic b);
    logic [14:0] sh;
    sh = {crc[13:0], 1'b0};
    return (b ^ crc[14]) ? (sh ^ CAN_CRC_POLY) : sh;
  endfunction

  // Number of payload bits on the bus for a given DLC/RTR.
  function automatic logic [6:0] can_data_bits(input logic [3:0] dlc, input logic rtr);
    if (rtr) return '0;
    if (dlc > 4'd8) return 7'd64;
    return {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_bit_timing.sv
// Bit-time counter with hard sync; emits mid-bit sample and end-of-bit wrap strobes.
module can_bit_timing
  import can_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_bit_time,
  input  logic        i_hard_sync,
  output logic        o_sample,
  output logic        o_wrap
);

  logic [15:0] r_cnt;
  logic [15:0] w_bt;

  assign w_bt     = (i_bit_time < 16'(CAN_MIN_BIT_TIME)) ? 16'(CAN_MIN_BIT_TIME) : i_bit_time;
  assign o_wrap   = !i_hard_sync && (r_cnt >= w_bt - 16'd1);
  assign o_sample = !i_hard_sync && (r_cnt == (w_bt >> 1));

  // The hard-sync cycle itself counts as position 0 of the new bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_cnt <= '0;
    else if (i_hard_sync) r_cnt <= 16'd1;
    else if (o_wrap)      r_cnt <= '0;
    else                  r_cnt <= r_cnt + 16'd1;
  end

endmodule

// File: rtl/can_rx_handler.sv
// CAN 2.0A receiver: hard sync, destuffing, CRC-15 check, ACK drive, frame delivery.
module can_rx_handler
  import can_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 32
) (
  input  logic                  clk_can,
  input  logic                  rst_n,
  input  logic                  can_rx,
  input  logic                  rx_enable,
  input  logic [15:0]           bit_time,
  output logic [ID_WIDTH-1:0]   rx_id,
  output logic [3:0]            rx_dlc,
  output logic                  rx_rtr,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  ack_drive,
  output logic                  stuff_err,
  output logic                  crc_err,
  output logic                  form_err
);

  logic r_sync1, r_sync, r_sync_d;
  logic w_hard_sync, w_sample, w_wrap, w_bit;
  can_rx_state_e r_state, w_state_nxt;
  logic [6:0]  r_bit_cnt, w_data_len;
  logic [2:0]  r_run_cnt;
  logic        r_last_bit;
  logic [14:0] r_crc, r_crc_rx;
  logic [10:0] r_id_sh, r_rx_id;
  logic        r_rtr_sh, r_rx_rtr;
  logic [3:0]  r_dlc_sh, r_rx_dlc, w_dlc_full;
  logic [DATA_WIDTH-1:0] r_data_sh, r_rx_data;
  logic [5:0]  w_data_idx;
  logic        w_stuff_zone, w_stuff_slot;
  logic        w_valid, w_stuff_err, w_crc_err, w_form_err;
  logic        r_rx_valid, r_stuff_err, r_crc_err, r_form_err, r_ack;

  always_ff @(posedge clk_can or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= can_rx;
      r_sync   <= r_sync1;
      r_sync_d <= r_sync;
    end
  end

  assign w_bit       = r_sync;
  assign w_hard_sync = (r_state == ST_IDLE) && rx_enable && r_sync_d && !r_sync;

  can_bit_timing u_bit_timing (
    .i_clk       (clk_can),
    .i_rst_n     (rst_n),
    .i_bit_time  (bit_time),
    .i_hard_sync (w_hard_sync),
    .o_sample    (w_sample),
    .o_wrap      (w_wrap)
  );

  // A stuff bit may still follow the last CRC bit; it is consumed while in CRC_DEL.
  assign w_stuff_zone = (r_state inside {[ST_SOF:ST_CRC]}) ||
                        ((r_state == ST_CRC_DEL) && (r_run_cnt == 3'd5));
  assign w_stuff_slot = w_stuff_zone && (r_run_cnt == 3'd5);
  assign w_dlc_full   = {r_dlc_sh[2:0], w_bit};
  assign w_data_len   = can_data_bits(r_dlc_sh, r_rtr_sh);
  assign w_data_idx   = {r_bit_cnt[5:3], ~r_bit_cnt[2:0]};

  always_ff @(posedge clk_can or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_stuff_err = 1'b0;
    w_crc_err   = 1'b0;
    w_form_err  = 1'b0;
    if (w_hard_sync) begin
      w_state_nxt = ST_SOF;
    end else if (w_sample && (r_state != ST_IDLE)) begin
      if (w_stuff_slot) begin
        if (w_bit == r_last_bit) begin
          w_stuff_err = 1'b1;
          w_state_nxt = ST_ERROR;
        end
      end else begin
        case (r_state)
          ST_SOF:  w_state_nxt = w_bit ? ST_IDLE : ST_ID;
          ST_ID:   if (r_bit_cnt == 7'(CAN_ID_LEN - 1)) w_state_nxt = ST_RTR;
          ST_RTR:  w_state_nxt = ST_IDE;
          ST_IDE:  w_state_nxt = w_bit ? ST_IGNORE : ST_R0;
          ST_R0:   w_state_nxt = ST_DLC;
          ST_DLC:
            if (r_bit_cnt == 7'(CAN_DLC_LEN - 1))
              w_state_nxt = (can_data_bits(w_dlc_full, r_rtr_sh) == '0) ? ST_CRC : ST_DATA;
          ST_DATA: if (r_bit_cnt == w_data_len - 7'd1) w_state_nxt = ST_CRC;
          ST_CRC:  if (r_bit_cnt == 7'(CAN_CRC_LEN - 1)) w_state_nxt = ST_CRC_DEL;
          ST_CRC_DEL: begin
            if (!w_bit) begin
              w_form_err  = 1'b1;
              w_state_nxt = ST_ERROR;
            end else if (r_crc_rx != r_crc) begin
              w_crc_err   = 1'b1;
              w_state_nxt = ST_ERROR;
            end else begin
              w_state_nxt = ST_ACK;
            end
          end
          ST_ACK:  w_state_nxt = ST_ACK_DEL;
          ST_ACK_DEL: begin
            w_form_err  = !w_bit;
            w_state_nxt = w_bit ? ST_EOF : ST_ERROR;
          end
          ST_EOF: begin
            if (!w_bit) begin
              w_form_err  = 1'b1;
              w_state_nxt = ST_ERROR;
            end else if (r_bit_cnt == 7'(CAN_EOF_LEN - 1)) begin
              w_valid     = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_ERROR, ST_IGNORE:
            if (w_bit && (r_bit_cnt == 7'(CAN_IDLE_RECOVERY - 1))) w_state_nxt = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_can or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_run_cnt   <= '0;
      r_last_bit  <= 1'b0;
      r_crc       <= '0;
      r_crc_rx    <= '0;
      r_id_sh     <= '0;
      r_rtr_sh    <= 1'b0;
      r_dlc_sh    <= '0;
      r_data_sh   <= '0;
      r_rx_id     <= '0;
      r_rx_rtr    <= 1'b0;
      r_rx_dlc    <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_stuff_err <= 1'b0;
      r_crc_err   <= 1'b0;
      r_form_err  <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_rx_valid  <= w_valid;
      r_stuff_err <= w_stuff_err;
      r_crc_err   <= w_crc_err;
      r_form_err  <= w_form_err;
      if (w_wrap) r_ack <= (r_state == ST_ACK);
      if (w_hard_sync) begin
        r_bit_cnt  <= '0;
        r_run_cnt  <= '0;
        r_last_bit <= 1'b0;
        r_crc      <= '0;
        r_crc_rx   <= '0;
        r_id_sh    <= '0;
        r_rtr_sh   <= 1'b0;
        r_dlc_sh   <= '0;
        r_data_sh  <= '0;
      end else if (w_sample && (r_state != ST_IDLE)) begin
        if (w_stuff_zone) begin
          r_last_bit <= w_bit;
          r_run_cnt  <= (w_stuff_slot || (w_bit != r_last_bit) || (r_run_cnt == '0)) ?
                        3'd1 : r_run_cnt + 3'd1;
        end
        if (w_state_nxt != r_state)
          r_bit_cnt <= '0;
        else if (!w_stuff_slot)
          r_bit_cnt <= ((r_state inside {ST_ERROR, ST_IGNORE}) && !w_bit) ? '0 : r_bit_cnt + 7'd1;
        if (!w_stuff_slot) begin
          if (r_state inside {[ST_SOF:ST_DATA]}) r_crc <= can_crc15_step(r_crc, w_bit);
          case (r_state)
            ST_ID:   r_id_sh  <= {r_id_sh[9:0], w_bit};
            ST_RTR:  r_rtr_sh <= w_bit;
            ST_DLC:  r_dlc_sh <= w_dlc_full;
            ST_DATA: r_data_sh[w_data_idx] <= w_bit;
            ST_CRC:  r_crc_rx <= {r_crc_rx[13:0], w_bit};
            default: ;
          endcase
        end
      end
      if (w_valid) begin
        r_rx_id   <= r_id_sh;
        r_rx_rtr  <= r_rtr_sh;
        r_rx_dlc  <= r_dlc_sh;
        r_rx_data <= r_data_sh;
      end
    end
  end

  assign rx_id     = {{(ID_WIDTH - 11){1'b0}}, r_rx_id};
  assign rx_dlc    = r_rx_dlc;
  assign rx_rtr    = r_rx_rtr;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign rx_busy   = (r_state != ST_IDLE);
  assign ack_drive = r_ack;
  assign stuff_err = r_stuff_err;
  assign crc_err   = r_crc_err;
  assign form_err  = r_form_err;

endmodule

// File: tb/tb_can_rx_handler.sv
// Directed bench for can_rx_handler: builds stuffed CAN frames and checks received fields and pulses.
module tb_can_rx_handler;

  logic        clk_can = 1'b0;
  logic        rst_n;
  logic        can_rx;
  logic        rx_enable;
  logic [15:0] bit_time;
  logic [31:0] rx_id;
  logic [3:0]  rx_dlc;
  logic        rx_rtr;
  logic [63:0] rx_data;
  logic        rx_valid, rx_busy, ack_drive, stuff_err, crc_err, form_err;

  int n_pass = 0;
  int n_total = 0;
  int n_valid = 0, n_ack = 0, n_stuff = 0, n_crc = 0, n_form = 0;
  int ack_run = 0, ack_last = 0;
  int b_valid, b_ack, b_stuff, b_crc, b_form;

  can_rx_handler #(.DATA_WIDTH(64), .ID_WIDTH(32)) dut (
    .clk_can   (clk_can),
    .rst_n     (rst_n),
    .can_rx    (can_rx),
    .rx_enable (rx_enable),
    .bit_time  (bit_time),
    .rx_id     (rx_id),
    .rx_dlc    (rx_dlc),
    .rx_rtr    (rx_rtr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .ack_drive (ack_drive),
    .stuff_err (stuff_err),
    .crc_err   (crc_err),
    .form_err  (form_err)
  );

  always #5 clk_can = ~clk_can;

  always @(negedge clk_can) begin
    if (rx_valid)  n_valid++;
    if (stuff_err) n_stuff++;
    if (crc_err)   n_crc++;
    if (form_err)  n_form++;
    if (ack_drive) begin
      n_ack++;
      ack_run++;
    end else if (ack_run != 0) begin
      ack_last = ack_run;
      ack_run  = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic snap();
    b_valid = n_valid; b_ack = n_ack; b_stuff = n_stuff; b_crc = n_crc; b_form = n_form;
  endtask

  task automatic drive_bit(input bit b);
    can_rx = b;
    repeat (10) @(posedge clk_can);
    #1;
  endtask

  function automatic logic [14:0] crc_of(input bit q[$]);
    logic [14:0] c;
    logic fb;
    c = '0;
    foreach (q[i]) begin
      fb = q[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    return c;
  endfunction

  // pl carries the payload in bus order: first transmitted bit is pl[63].
  task automatic send_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] pl, input bit flip_crc, input bit bad_del,
                            input int abort_at);
    bit raw[$];
    bit st[$];
    logic [14:0] c;
    int nd, run;
    bit last;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nd = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
    for (int k = 0; k < nd; k++) raw.push_back(pl[63 - k]);
    c = crc_of(raw);
    if (flip_crc) c[3] = ~c[3];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    run = 0;
    last = 1'b0;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      run  = (run != 0 && raw[i] == last) ? run + 1 : 1;
      last = raw[i];
      if (run == 5) begin
        st.push_back(!last);
        last = !last;
        run  = 1;
      end
    end
    st.push_back(!bad_del);
    repeat (12) st.push_back(1'b1);
    foreach (st[i]) if (abort_at < 0 || i < abort_at) drive_bit(st[i]);
  endtask

  initial begin
    logic [10:0] idv;
    rst_n = 1'b0; can_rx = 1'b1; rx_enable = 1'b1; bit_time = 16'd10;
    repeat (3) @(posedge clk_can);
    #1;
    chk("reset_id", rx_id, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_ctl", {rx_dlc, rx_rtr, rx_valid, rx_busy, ack_drive, stuff_err, crc_err, form_err}, 0);
    rst_n = 1'b1;
    repeat (12) drive_bit(1'b1);

    snap();
    send_frame(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0, 1'b0, -1);
    chk("good_valid_cnt", n_valid - b_valid, 1);
    chk("good_id", rx_id, 64'h123);
    chk("good_dlc", rx_dlc, 2);
    chk("good_rtr", rx_rtr, 0);
    chk("good_data", rx_data, 64'h0000_0000_0000_CDAB);
    chk("good_ack_cycles", n_ack - b_ack, 10);
    chk("good_ack_run", ack_last, 10);
    chk("good_errs", (n_stuff - b_stuff) + (n_crc - b_crc) + (n_form - b_form), 0);
    chk("good_busy_after", rx_busy, 0);

    snap();
    send_frame(11'h000, 1'b0, 4'd0, 64'h0, 1'b0, 1'b0, -1);
    chk("stuff_valid_cnt", n_valid - b_valid, 1);
    chk("stuff_id", rx_id, 0);
    chk("stuff_data", rx_data, 0);
    chk("stuff_errs", (n_stuff - b_stuff) + (n_crc - b_crc) + (n_form - b_form), 0);

    snap();
    send_frame(11'h4F0, 1'b0, 4'd15, 64'h1122_3344_5566_7788, 1'b0, 1'b0, -1);
    chk("dlc15_valid_cnt", n_valid - b_valid, 1);
    chk("dlc15_id", rx_id, 64'h4F0);
    chk("dlc15_dlc", rx_dlc, 15);
    chk("dlc15_data", rx_data, 64'h8877_6655_4433_2211);

    snap();
    send_frame(11'h2A5, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, -1);
    chk("rtr_valid_cnt", n_valid - b_valid, 1);
    chk("rtr_id", rx_id, 64'h2A5);
    chk("rtr_flag", rx_rtr, 1);
    chk("rtr_dlc", rx_dlc, 3);
    chk("rtr_data", rx_data, 0);

    snap();
    repeat (6) drive_bit(1'b0);
    repeat (15) drive_bit(1'b1);
    chk("stuffviol_cnt", n_stuff - b_stuff, 1);
    chk("stuffviol_ack", n_ack - b_ack, 0);
    chk("stuffviol_valid", n_valid - b_valid, 0);
    chk("stuffviol_busy", rx_busy, 0);
    chk("stuffviol_id_hold", rx_id, 64'h2A5);

    snap();
    send_frame(11'h3C1, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1'b1, 1'b0, -1);
    drive_bit(1'b1);
    chk("crcerr_cnt", n_crc - b_crc, 1);
    chk("crcerr_ack", n_ack - b_ack, 0);
    chk("crcerr_valid", n_valid - b_valid, 0);
    chk("crcerr_id_hold", rx_id, 64'h2A5);
    chk("crcerr_rtr_hold", rx_rtr, 1);
    chk("crcerr_busy", rx_busy, 0);

    snap();
    send_frame(11'h0F0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1'b0, 1'b1, -1);
    drive_bit(1'b1);
    chk("crcdel_form_cnt", n_form - b_form, 1);
    chk("crcdel_crc_cnt", n_crc - b_crc, 0);
    chk("crcdel_valid", n_valid - b_valid, 0);

    snap();
    idv = 11'h555;
    drive_bit(1'b0);
    for (int i = 10; i >= 0; i--) drive_bit(idv[i]);
    drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (10) drive_bit(1'b1);
    chk("ide_busy_10", rx_busy, 1);
    drive_bit(1'b1);
    chk("ide_busy_11", rx_busy, 0);
    chk("ide_pulses", (n_stuff - b_stuff) + (n_crc - b_crc) + (n_form - b_form) + (n_valid - b_valid), 0);
    chk("ide_ack", n_ack - b_ack, 0);
    repeat (2) drive_bit(1'b1);

    snap();
    rx_enable = 1'b0;
    send_frame(11'h111, 1'b0, 4'd1, 64'h0100_0000_0000_0000, 1'b0, 1'b0, -1);
    chk("disabled_valid", n_valid - b_valid, 0);
    chk("disabled_busy", rx_busy, 0);
    rx_enable = 1'b1;

    send_frame(11'h7FF, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 30);
    chk("midframe_busy", rx_busy, 1);
    rst_n = 1'b0;
    can_rx = 1'b1;
    #1;
    chk("midrst_id", rx_id, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_ctl", {rx_dlc, rx_rtr, rx_valid, rx_busy, ack_drive, stuff_err, crc_err, form_err}, 0);
    repeat (3) @(posedge clk_can);
    #1;
    rst_n = 1'b1;
    repeat (11) drive_bit(1'b1);

    snap();
    send_frame(11'h7FF, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, -1);
    chk("post_rst_valid_cnt", n_valid - b_valid, 1);
    chk("post_rst_id", rx_id, 64'h7FF);
    chk("post_rst_dlc", rx_dlc, 8);
    chk("post_rst_data", rx_data, 64'hEFCD_AB89_6745_2301);
    chk("post_rst_ack", n_ack - b_ack, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
